// File: rtl/toast_lsu_pkg.sv
// toast_lsu_pkg: shared definitions for the load/store unit.
//   - RV32I load/store funct3 encodings
//   - LSU FSM state type
//   - byte-enable and misalignment helpers, shared by the LSU and any bypass path
package toast_lsu_pkg;

  localparam logic [2:0] LSU_LB  = 3'b000;
  localparam logic [2:0] LSU_LH  = 3'b001;
  localparam logic [2:0] LSU_LW  = 3'b010;
  localparam logic [2:0] LSU_LBU = 3'b100;
  localparam logic [2:0] LSU_LHU = 3'b101;
  localparam logic [2:0] LSU_SB  = 3'b000;
  localparam logic [2:0] LSU_SH  = 3'b001;
  localparam logic [2:0] LSU_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2
  } lsu_state_e;

  // Byte lanes touched by an access; size comes from funct3[1:0].
  function automatic logic [3:0] lsu_byte_en(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic m;
    case (f3[1:0])
      2'b01:   m = a[0];
      2'b10:   m = |a;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/toast_lsu_load_align.sv
// toast_load_align: combinational load-data formatter.
//   rdata  : raw 32-bit word from data memory
//   addr   : byte offset of the access within the word
//   funct3 : RV32I load funct3
//   data   : lane-aligned, sign/zero-extended result
module toast_load_align
  import toast_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] lane;

  assign lane = rdata >> {addr, 3'b000};

  always_comb begin
    data = lane;
    case (funct3)
      LSU_LB:  data = {{24{lane[7]}}, lane[7:0]};
      LSU_LH:  data = {{16{lane[15]}}, lane[15:0]};
      LSU_LBU: data = {24'h0, lane[7:0]};
      LSU_LHU: data = {16'h0, lane[15:0]};
      LSU_LW:  data = rdata;
      default: data = lane;
    endcase
  end

endmodule

// File: rtl/toast_lsu.sv
// toast_lsu: load/store unit behind the EX-stage ALU.
//   ALIGN_CHECK    : 1 = suppress misaligned half/word accesses and flag them
//   clk_i/resetn_i : clock, synchronous active-low reset
//   ex_*           : operation from EX (alu_result_i is the effective address)
//   lsu_stall_o    : freezes IF/ID/EX while an access is accepted/outstanding
//   dmem_*         : request/grant/response data-memory port
//   wb_*           : formatted load result, wb_valid_o pulses for one cycle
//   misalign_*     : one-cycle pulse plus faulting address
module toast_lsu
  import toast_lsu_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        ex_valid_i,
  input  logic        ex_mem_rd_i,
  input  logic        ex_mem_wr_i,
  input  logic [2:0]  ex_funct3_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] ex_rs2_i,
  input  logic [4:0]  ex_rd_i,
  output logic        lsu_stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        misalign_o,
  output logic [31:0] misalign_addr_o
);

  lsu_state_e  state, state_n;
  logic        is_ld, is_st, f3_legal, misal, op_valid, accept, misal_evt;
  logic [31:0] addr_q, wdata_q, wdata_fmt, ld_data;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic [3:0]  be_q;
  logic        we_q;

  // Load wins when both rd and wr are set.
  assign is_ld = ex_mem_rd_i;
  assign is_st = ex_mem_wr_i & ~ex_mem_rd_i;

  always_comb begin
    f3_legal = 1'b0;
    if (is_ld)
      f3_legal = ex_funct3_i inside {LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU};
    else if (is_st)
      f3_legal = ex_funct3_i inside {LSU_SB, LSU_SH, LSU_SW};
  end

  assign misal     = ALIGN_CHECK && lsu_misaligned(ex_funct3_i, alu_result_i[1:0]);
  assign op_valid  = (state == LSU_IDLE) & ex_valid_i & (is_ld | is_st) & f3_legal;
  assign accept    = op_valid & ~misal;
  assign misal_evt = op_valid & misal;

  always_comb begin
    case (ex_funct3_i[1:0])
      2'b00:   wdata_fmt = {4{ex_rs2_i[7:0]}};
      2'b01:   wdata_fmt = {2{ex_rs2_i[15:0]}};
      default: wdata_fmt = ex_rs2_i;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      LSU_IDLE: if (accept) state_n = LSU_REQ;
      LSU_REQ:  if (dmem_gnt_i) state_n = we_q ? LSU_IDLE : LSU_WAIT;
      LSU_WAIT: if (dmem_rvalid_i) state_n = LSU_IDLE;
      default:  state_n = LSU_IDLE;
    endcase
  end

  toast_load_align u_align (
    .rdata  (dmem_rdata_i),
    .addr   (addr_q[1:0]),
    .funct3 (f3_q),
    .data   (ld_data)
  );

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state           <= LSU_IDLE;
      addr_q          <= '0;
      wdata_q         <= '0;
      f3_q            <= '0;
      rd_q            <= '0;
      be_q            <= '0;
      we_q            <= 1'b0;
      wb_valid_o      <= 1'b0;
      wb_rd_o         <= '0;
      wb_data_o       <= '0;
      misalign_o      <= 1'b0;
      misalign_addr_o <= '0;
    end else begin
      state      <= state_n;
      wb_valid_o <= (state == LSU_WAIT) & dmem_rvalid_i;
      misalign_o <= misal_evt;
      if (accept) begin
        addr_q  <= alu_result_i;
        wdata_q <= wdata_fmt;
        f3_q    <= ex_funct3_i;
        rd_q    <= ex_rd_i;
        be_q    <= lsu_byte_en(ex_funct3_i, alu_result_i[1:0]);
        we_q    <= is_st;
      end
      if ((state == LSU_WAIT) && dmem_rvalid_i) begin
        wb_data_o <= ld_data;
        wb_rd_o   <= rd_q;
      end
      if (misal_evt) misalign_addr_o <= alu_result_i;
    end
  end

  assign lsu_stall_o  = accept | (state != LSU_IDLE);
  assign dmem_req_o   = (state == LSU_REQ);
  assign dmem_we_o    = (state == LSU_REQ) & we_q;
  assign dmem_addr_o  = {addr_q[31:2], 2'b00};
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;

endmodule

// File: tb/tb_toast_lsu.sv
// tb_toast_lsu: table-driven self-checking bench for toast_lsu with a
// scoreboard of expected memory requests, writebacks and misalign pulses.
module tb_toast_lsu;
  import toast_lsu_pkg::*;

  logic        clk, resetn;
  logic        ex_valid, ex_mem_rd, ex_mem_wr;
  logic [2:0]  ex_funct3;
  logic [31:0] alu_result, ex_rs2;
  logic [4:0]  ex_rd;
  logic        lsu_stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic        wb_valid, misalign;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, misalign_addr;

  toast_lsu #(.ALIGN_CHECK(1'b1)) dut (
    .clk_i           (clk),
    .resetn_i        (resetn),
    .ex_valid_i      (ex_valid),
    .ex_mem_rd_i     (ex_mem_rd),
    .ex_mem_wr_i     (ex_mem_wr),
    .ex_funct3_i     (ex_funct3),
    .alu_result_i    (alu_result),
    .ex_rs2_i        (ex_rs2),
    .ex_rd_i         (ex_rd),
    .lsu_stall_o     (lsu_stall),
    .dmem_req_o      (dmem_req),
    .dmem_we_o       (dmem_we),
    .dmem_addr_o     (dmem_addr),
    .dmem_be_o       (dmem_be),
    .dmem_wdata_o    (dmem_wdata),
    .dmem_gnt_i      (dmem_gnt),
    .dmem_rvalid_i   (dmem_rvalid),
    .dmem_rdata_i    (dmem_rdata),
    .wb_valid_o      (wb_valid),
    .wb_rd_o         (wb_rd),
    .wb_data_o       (wb_data),
    .misalign_o      (misalign),
    .misalign_addr_o (misalign_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum logic [1:0] {K_ACC, K_MIS, K_ILL} kind_e;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [4:0]  rdst;
    logic [31:0] rdata;
    int unsigned gd;
    int unsigned rv;
    kind_e       kind;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] wb;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  req_t        req_q[$];
  wb_t         wb_q[$];
  logic [31:0] mis_q[$];
  vec_t        vecs[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] rs2,
                              input logic [4:0] rdst, input logic [31:0] rdata,
                              input int unsigned gd, input int unsigned rv, input kind_e kind,
                              input logic [3:0] be, input logic [31:0] wdata,
                              input logic [31:0] wb);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.rs2 = rs2; v.rdst = rdst;
    v.rdata = rdata; v.gd = gd; v.rv = rv; v.kind = kind; v.be = be;
    v.wdata = wdata; v.wb = wb;
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rdst);
    ex_valid = 1'b1; ex_mem_rd = rd; ex_mem_wr = wr; ex_funct3 = f3;
    alu_result = addr; ex_rs2 = rs2; ex_rd = rdst;
  endtask

  task automatic idle_ex();
    ex_valid = 1'b0; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0;
  endtask

  task automatic all_zero(input string name);
    chk(name, {31'h0, |{dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, wb_valid,
                        wb_rd, wb_data, lsu_stall, misalign, misalign_addr}}, 32'h0);
  endtask

  // Called at a negedge; returns at a negedge with EX idle.
  task automatic run_vec(input vec_t v);
    int unsigned stall_cnt;
    req_t r;
    wb_t  w;
    logic [31:0] ma;
    stall_cnt = 0;
    drive_op(v.rd, v.wr, v.f3, v.addr, v.rs2, v.rdst);
    #1;
    if (v.kind == K_ACC) begin
      r.we = v.wr & ~v.rd; r.addr = {v.addr[31:2], 2'b00}; r.be = v.be; r.wdata = v.wdata;
      req_q.push_back(r);
      if (v.rd) begin
        w.rd = v.rdst; w.data = v.wb;
        wb_q.push_back(w);
      end
      chk("accept_stall", {31'h0, lsu_stall}, 32'h1);
      if (lsu_stall) stall_cnt++;
    end else begin
      if (v.kind == K_MIS) mis_q.push_back(v.addr);
      chk("reject_stall", {31'h0, lsu_stall}, 32'h0);
    end
    next_cycle();
    idle_ex();
    #1;
    if (v.kind == K_ACC) begin
      r = req_q.pop_front();
      for (int unsigned c = 0; c <= v.gd; c++) begin
        chk("req", {31'h0, dmem_req}, 32'h1);
        chk("req_we", {31'h0, dmem_we}, {31'h0, r.we});
        chk("req_addr", dmem_addr, r.addr);
        chk("req_be", {28'h0, dmem_be}, {28'h0, r.be});
        if (r.we) chk("req_wdata", dmem_wdata, r.wdata);
        if (lsu_stall) stall_cnt++;
        dmem_gnt = (c == v.gd);
        next_cycle();
        dmem_gnt = 1'b0;
        #1;
      end
      if (v.rd) begin
        for (int unsigned k = 0; k < v.rv; k++) begin
          chk("wait_no_req", {31'h0, dmem_req}, 32'h0);
          chk("wait_no_wb", {31'h0, wb_valid}, 32'h0);
          if (lsu_stall) stall_cnt++;
          if (k == v.rv - 1) begin
            dmem_rvalid = 1'b1;
            dmem_rdata = v.rdata;
          end
          next_cycle();
          dmem_rvalid = 1'b0;
          dmem_rdata = $urandom;
          #1;
        end
        chk("wb_valid", {31'h0, wb_valid}, 32'h1);
        if (wb_q.size() == 0) chk("wb_sb_empty", 32'h1, 32'h0);
        else begin
          w = wb_q.pop_front();
          chk("wb_data", wb_data, w.data);
          chk("wb_rd", {27'h0, wb_rd}, {27'h0, w.rd});
        end
        chk("ld_stall_cycles", stall_cnt, 1 + (v.gd + 1) + v.rv);
        chk("ld_stall_low", {31'h0, lsu_stall}, 32'h0);
        next_cycle();
        #1;
        chk("wb_single_pulse", {31'h0, wb_valid}, 32'h0);
        chk("wb_data_hold", wb_data, v.wb);
      end else begin
        chk("st_stall_cycles", stall_cnt, 1 + (v.gd + 1));
        chk("st_stall_low", {31'h0, lsu_stall}, 32'h0);
        chk("st_req_low", {31'h0, dmem_req}, 32'h0);
      end
    end else if (v.kind == K_MIS) begin
      chk("mis_pulse", {31'h0, misalign}, 32'h1);
      if (mis_q.size() == 0) chk("mis_sb_empty", 32'h1, 32'h0);
      else begin
        ma = mis_q.pop_front();
        chk("mis_addr", misalign_addr, ma);
      end
      chk("mis_no_req", {31'h0, dmem_req}, 32'h0);
      chk("mis_no_stall", {31'h0, lsu_stall}, 32'h0);
      next_cycle();
      #1;
      chk("mis_pulse_end", {31'h0, misalign}, 32'h0);
    end else begin
      chk("ill_no_req", {31'h0, dmem_req}, 32'h0);
      chk("ill_no_pulse", {31'h0, misalign}, 32'h0);
      chk("ill_no_stall", {31'h0, lsu_stall}, 32'h0);
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vecs.push_back(mk(0, 1, LSU_SW,  32'h100, 32'hDEADBEEF, 5'd0,  32'h0,        0, 0, K_ACC, 4'b1111, 32'hDEADBEEF, 32'h0));
    vecs.push_back(mk(0, 1, LSU_SB,  32'h103, 32'h000000A5, 5'd0,  32'h0,        1, 0, K_ACC, 4'b1000, 32'hA5A5A5A5, 32'h0));
    vecs.push_back(mk(0, 1, LSU_SH,  32'h102, 32'h1234ABCD, 5'd0,  32'h0,        0, 0, K_ACC, 4'b1100, 32'hABCDABCD, 32'h0));
    vecs.push_back(mk(1, 0, LSU_LB,  32'h102, 32'h0,        5'd5,  32'h12F04455, 0, 1, K_ACC, 4'b0100, 32'h0, 32'hFFFFFFF0));
    vecs.push_back(mk(1, 0, LSU_LBU, 32'h102, 32'h0,        5'd6,  32'h12F04455, 0, 1, K_ACC, 4'b0100, 32'h0, 32'h000000F0));
    vecs.push_back(mk(1, 0, LSU_LHU, 32'h102, 32'h0,        5'd7,  32'h12F04455, 0, 1, K_ACC, 4'b1100, 32'h0, 32'h000012F0));
    vecs.push_back(mk(1, 0, LSU_LH,  32'h100, 32'h0,        5'd8,  32'h00008001, 0, 3, K_ACC, 4'b0011, 32'h0, 32'hFFFF8001));
    vecs.push_back(mk(1, 0, LSU_LW,  32'h204, 32'h0,        5'd9,  32'hCAFEF00D, 3, 2, K_ACC, 4'b1111, 32'h0, 32'hCAFEF00D));
    vecs.push_back(mk(1, 0, LSU_LH,  32'h101, 32'h0,        5'd10, 32'h0,        0, 0, K_MIS, 4'b0000, 32'h0, 32'h0));
    vecs.push_back(mk(1, 0, LSU_LB,  32'h001, 32'h0,        5'd0,  32'h00007F00, 0, 1, K_ACC, 4'b0010, 32'h0, 32'h0000007F));
    vecs.push_back(mk(1, 0, 3'b011,  32'h300, 32'h0,        5'd11, 32'h0,        0, 0, K_ILL, 4'b0000, 32'h0, 32'h0));
    vecs.push_back(mk(0, 1, LSU_SW,  32'h102, 32'h55555555, 5'd0,  32'h0,        0, 0, K_MIS, 4'b0000, 32'h0, 32'h0));
    vecs.push_back(mk(0, 1, 3'b100,  32'h300, 32'h66666666, 5'd0,  32'h0,        0, 0, K_ILL, 4'b0000, 32'h0, 32'h0));
    vecs.push_back(mk(1, 1, LSU_LBU, 32'h003, 32'h77777777, 5'd12, 32'h80000000, 2, 1, K_ACC, 4'b1000, 32'h0, 32'h00000080));

    resetn = 1'b0; idle_ex(); ex_funct3 = '0; alu_result = '0; ex_rs2 = '0; ex_rd = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    next_cycle();
    next_cycle();
    #1;
    all_zero("reset_outputs");
    resetn = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back stores: second accepted in the cycle the FSM returns to IDLE.
    drive_op(1'b0, 1'b1, LSU_SW, 32'h40, 32'h11111111, 5'd0);
    next_cycle();
    idle_ex();
    #1;
    chk("b2b_a_addr", dmem_addr, 32'h40);
    dmem_gnt = 1'b1;
    next_cycle();
    dmem_gnt = 1'b0;
    drive_op(1'b0, 1'b1, LSU_SW, 32'h44, 32'h22222222, 5'd0);
    #1;
    chk("b2b_stall_held", {31'h0, lsu_stall}, 32'h1);
    next_cycle();
    idle_ex();
    #1;
    chk("b2b_b_req", {31'h0, dmem_req}, 32'h1);
    chk("b2b_b_addr", dmem_addr, 32'h44);
    chk("b2b_b_wdata", dmem_wdata, 32'h22222222);
    dmem_gnt = 1'b1;
    next_cycle();
    dmem_gnt = 1'b0;
    #1;
    chk("b2b_done", {31'h0, lsu_stall}, 32'h0);

    // Reset during WAIT abandons the load; a late rvalid must be ignored.
    drive_op(1'b1, 1'b0, LSU_LW, 32'h300, 32'h0, 5'd3);
    next_cycle();
    idle_ex();
    dmem_gnt = 1'b1;
    next_cycle();
    dmem_gnt = 1'b0;
    #1;
    chk("rst_in_wait_stall", {31'h0, lsu_stall}, 32'h1);
    resetn = 1'b0;
    next_cycle();
    resetn = 1'b1;
    #1;
    all_zero("rst_mid_outputs");
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h99999999;
    next_cycle();
    dmem_rvalid = 1'b0;
    #1;
    chk("stray_rvalid_no_wb", {31'h0, wb_valid}, 32'h0);
    chk("stray_rvalid_no_stall", {31'h0, lsu_stall}, 32'h0);
    next_cycle();
    #1;
    chk("stray_rvalid_no_wb_late", {31'h0, wb_valid}, 32'h0);
    run_vec(mk(1, 0, LSU_LW, 32'h308, 32'h0, 5'd4, 32'h0BADF00D, 1, 1, K_ACC, 4'b1111, 32'h0, 32'h0BADF00D));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/toast_lsu.md
# toast_lsu

Load/store unit directly downstream of the execute-stage ALU. Takes the ALU result as the effective address, plus store data and funct3 from the EX stage. Runs a three-state request/grant/response handshake with data memory and stalls the pipeline while an access is outstanding. Delivers aligned, sign- or zero-extended load data to writeback.

## Interface
- `ALIGN_CHECK`, 1, 1 = detect misaligned half/word accesses and suppress them; 0 = access issued with address low bits ignored
- `clk_i  in  1  single clock, all state on rising edge`
- `resetn_i  in  1  synchronous, active-low reset`
- `ex_valid_i  in  1  EX stage holds a valid instruction this cycle`
- `ex_mem_rd_i  in  1  instruction is a load`
- `ex_mem_wr_i  in  1  instruction is a store (rd has priority if both set)`
- `ex_funct3_i  in  3  RV32I load/store funct3`
- `alu_result_i  in  32  effective address (rs1 + imm from ALU_ADD)`
- `ex_rs2_i  in  32  store data`
- `ex_rd_i  in  5  load destination register`
- `lsu_stall_o  out  1  freeze IF/ID/EX`
- `dmem_req_o  out  1`, `dmem_we_o  out  1`, `dmem_addr_o  out  32  word-aligned ({addr[31:2],2'b00})`, `dmem_be_o  out  4`, `dmem_wdata_o  out  32`
- `dmem_gnt_i  in  1`, `dmem_rvalid_i  in  1`, `dmem_rdata_i  in  32`
- `wb_valid_o  out  1`, `wb_rd_o  out  5`, `wb_data_o  out  32`
- `misalign_o  out  1  one-cycle pulse`, `misalign_addr_o  out  32  faulting address`

## Operation
- States: IDLE, REQ, WAIT.
- **Accept condition:** IDLE & ex_valid_i & (rd|wr) & funct3 legal & aligned.
  - On accept, latch addr, funct3, rd, be, wdata, we; next state is REQ.
- **REQ:** dmem_req_o=1 and all dmem_* outputs held stable until dmem_gnt_i.
  - Gnt on a store: next state IDLE.
  - Gnt on a load: next state WAIT.
- **WAIT:** on dmem_rvalid_i, register the formatted data, wb_valid_o=1 next cycle, next state IDLE.
- **Misalignment (ALIGN_CHECK=1):** half with addr[0]≠0, or word with addr[1:0]≠0.
  - No request, no stall; state stays IDLE.
  - Next cycle: misalign_o=1 for one cycle, misalign_addr_o=addr.
- **Illegal funct3** (load 011/110/111, store 011/1xx): ignored; no access, no stall, no pulse.
- **Store formatting:**
  - SB: be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: be=addr[1]?4'b1100:4'b0011, wdata={2{rs2[15:0]}}.
  - SW: be=4'b1111, wdata=rs2.
- **Load formatting:** lane = rdata>>(8·addr[1:0]).
  - LB/LH: sign-extend from bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: pass through.
  - dmem_be_o for loads uses the same pattern as stores.
- Loads to x0 still access memory; wb_valid_o asserted with wb_rd_o=0.
- rvalid seen in IDLE or REQ is ignored.

## Timing
- **Reset:** after any cycle with resetn_i=0, state=IDLE and every output is 0: dmem_*, wb_*, lsu_stall_o, misalign_*. A reset mid-access abandons it; later rvalid is ignored.
- lsu_stall_o = accept | (state≠IDLE). It is combinational and high from the accept cycle.
- **Store latency:** accept at N, req at N+1. Zero-wait gnt at N+1 gives IDLE at N+2, stall low at N+2.
- **Load latency:** accept N, gnt N+1, earliest rvalid N+2.
  - wb_valid_o=1 at N+3, stall low at N+3.
  - wb_valid_o is a single-cycle pulse; wb_data_o/wb_rd_o hold until the next load.
- Memory contract: rvalid never in the same cycle as its gnt; exactly one rvalid per granted load.
- Back-to-back: a new op can be accepted in the cycle the FSM returns to IDLE (stall then stays high).

## Structure
- `toast_definitions.vh` gains:
  - funct3 constants: LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU, LSU_SB, LSU_SH, LSU_SW.
  - LSU state encodings.
- One combinational sub-module, `toast_load_align`: inputs rdata, addr[1:0], funct3; output formatted 32-bit data. It is shared with any future bypass path.

## Test plan
- SW at 0x100, rs2=0xDEADBEEF, gnt at first REQ cycle → addr=0x100, be=1111, wdata=0xDEADBEEF, we=1; stall high exactly 2 cycles.
- SB at 0x103, rs2=0x000000A5 → be=1000, wdata=0xA5A5A5A5.
- LB at 0x102, rdata=0x12F04455 → wb_data=0xFFFFFFF0. LBU at the same address → 0x000000F0. LHU at 0x102 → 0x000012F0. wb_rd matches ex_rd.
- LW at 0x204, gnt delayed 3 cycles, rvalid 2 cycles after gnt → dmem outputs stable throughout REQ; stall high 7 cycles; single wb_valid pulse.
- LH at 0x101 → no dmem_req; misalign_o pulse with misalign_addr_o=0x101; stall never high.
- resetn_i low during WAIT, then stray rvalid → no wb_valid; all outputs 0; next load completes normally.
